// File: rtl/multiport_regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
package multiport_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 3;

  // Clear-sweep controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_read_mux.sv
// One combinational read port of the register file.
// Optional build macro MULTIPORT_REGFILE_BYPASS_EN: forwards same-cycle
// accepted write data to the read data (port B beats port A). The pending
// flag is never forwarded; it always reflects the stored pend bit.
module regfile_read_mux
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  input  logic [DEPTH-1:0]  pend_i,
`ifdef MULTIPORT_REGFILE_BYPASS_EN
  input  logic              wr_a_acc_i,
  input  logic [ADDR_W-1:0] wr_addr_a_i,
  input  logic [DATA_W-1:0] wr_data_a_i,
  input  logic              wr_b_acc_i,
  input  logic [ADDR_W-1:0] wr_addr_b_i,
  input  logic [DATA_W-1:0] wr_data_b_i,
`endif
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_pend_o
);

  // Select stored data, overridden by a same-cycle write when forwarding is built in
  always_comb begin
    rd_data_o = mem_i[rd_addr_i];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
    if (wr_b_acc_i && (wr_addr_b_i == rd_addr_i)) begin
      rd_data_o = wr_data_b_i;
    end else if (wr_a_acc_i && (wr_addr_a_i == rd_addr_i)) begin
      rd_data_o = wr_data_a_i;
    end else begin
      rd_data_o = mem_i[rd_addr_i];
    end
`endif
  end

  // Pending flag of the addressed register, straight from storage
  always_comb begin
    rd_pend_o = pend_i[rd_addr_i];
  end

endmodule

// File: rtl/multiport_regfile.sv
// Two-write / NUM_RD-read register file with per-register pending flags and
// a hardware clear sweep that zeroes one register per cycle.
// Optional build macro MULTIPORT_REGFILE_BYPASS_EN enables write-to-read
// forwarding in every read port.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     nRESET,
  input  logic                     wr_en_a,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic [DATA_W-1:0]        wr_data_a,
  input  logic                     wr_en_b,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic [DATA_W-1:0]        wr_data_b,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  logic wr_a_acc_s;
  logic wr_b_acc_s;

  // Host writes and pend marks are only accepted outside the sweep
  always_comb begin
    wr_a_acc_s = wr_en_a & ~busy_q;
    wr_b_acc_s = wr_en_b & ~busy_q;
  end

  // Next-state of storage: sweep clears one entry, otherwise A then B then pend_set
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (busy_q) begin
      mem_d[cnt_q]  = '0;
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (wr_a_acc_s) begin
        mem_d[wr_addr_a]  = wr_data_a;
        pend_d[wr_addr_a] = 1'b0;
      end else begin
        mem_d[wr_addr_a] = mem_d[wr_addr_a];
      end
      // B is applied after A so it wins a same-address collision
      if (wr_b_acc_s) begin
        mem_d[wr_addr_b]  = wr_data_b;
        pend_d[wr_addr_b] = 1'b0;
      end else begin
        mem_d[wr_addr_b] = mem_d[wr_addr_b];
      end
      // Marking pending beats a same-cycle writeback clear
      if (pend_set) begin
        pend_d[pend_addr] = 1'b1;
      end else begin
        pend_d[pend_addr] = pend_d[pend_addr];
      end
    end
  end

  // Register array and pend bits, cleared asynchronously by reset
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Clear-sweep FSM: walks cnt over every register, busy flag tracks SWEEP
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_q;

  // One read mux per read port
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .rd_addr_i   (rd_addr[g*ADDR_W +: ADDR_W]),
      .mem_i       (mem_q),
      .pend_i      (pend_q),
`ifdef MULTIPORT_REGFILE_BYPASS_EN
      .wr_a_acc_i  (wr_a_acc_s),
      .wr_addr_a_i (wr_addr_a),
      .wr_data_a_i (wr_data_a),
      .wr_b_acc_i  (wr_b_acc_s),
      .wr_addr_b_i (wr_addr_b),
      .wr_data_b_i (wr_data_b),
`endif
      .rd_data_o   (rd_data[g*DATA_W +: DATA_W]),
      .rd_pend_o   (rd_pend[g])
    );
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile (default parameters).
module tb_multiport_regfile;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 3;

`ifdef MULTIPORT_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     nRESET;
  logic                     wr_en_a, wr_en_b;
  logic [ADDR_W-1:0]        wr_addr_a, wr_addr_b;
  logic [DATA_W-1:0]        wr_data_a, wr_data_b;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic                     clr_req;
  logic                     clr_busy;

  always #5 clk = ~clk;

  multiport_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .nRESET(nRESET),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  // Scoreboard entry: kind 0 = rd_data, 1 = rd_pend, 2 = clr_busy
  typedef struct {
    string             name;
    int                kind;
    int                port;
    logic [DATA_W-1:0] exp;
  } sb_t;

  typedef struct {
    string             name;
    logic              we_a;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] da;
    logic              we_b;
    logic [ADDR_W-1:0] wb;
    logic [DATA_W-1:0] db;
    logic              ps;
    logic [ADDR_W-1:0] pa;
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] ed [NUM_RD];
    logic              ep [NUM_RD];
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl [13];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string n, logic wea, logic [2:0] wa, logic [15:0] da,
                              logic web, logic [2:0] wb, logic [15:0] db,
                              logic ps, logic [2:0] pa,
                              logic [2:0] r0, logic [2:0] r1, logic [2:0] r2,
                              logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                              logic p0, logic p1, logic p2);
    vec_t v;
    v.name = n; v.we_a = wea; v.wa = wa; v.da = da;
    v.we_b = web; v.wb = wb; v.db = db; v.ps = ps; v.pa = pa;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.ep[0] = p0; v.ep[1] = p1; v.ep[2] = p2;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] actual(int kind, int port);
    logic [DATA_W-1:0] r;
    r = '0;
    case (kind)
      0:       r = rd_data[port*DATA_W +: DATA_W];
      1:       r[0] = rd_pend[port];
      default: r[0] = clr_busy;
    endcase
    return r;
  endfunction

  task automatic push(string name, int kind, int port, logic [DATA_W-1:0] exp);
    sb_t e;
    e.name = name; e.kind = kind; e.port = port; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    sb_t e;
    logic [DATA_W-1:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = actual(e.kind, e.port);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s (kind %0d port %0d): got %h, expected %h",
                 e.name, e.kind, e.port, act, e.exp);
      end
    end
  endtask

  task automatic idle_in();
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0;
  endtask

  task automatic set_rd(logic [2:0] r0, logic [2:0] r1, logic [2:0] r2);
    rd_addr = {r2, r1, r0};
  endtask

  task automatic wr_a(logic [2:0] a, logic [15:0] d);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
  endtask

  initial begin
    nRESET = 1'b0;
    idle_in();
    set_rd(3'd0, 3'd0, 3'd0);

    tbl[0]  = mk("reset_state", 0,0,16'h0,    0,0,16'h0,    0,0, 0,1,2, 16'h0,16'h0,16'h0, 0,0,0);
    tbl[1]  = mk("wrA2",        1,2,16'h1234, 0,0,16'h0,    0,0, 0,1,3, 16'h0,16'h0,16'h0, 0,0,0);
    tbl[2]  = mk("rd2",         0,0,16'h0,    0,0,16'h0,    0,0, 2,0,7, 16'h1234,16'h0,16'h0, 0,0,0);
    tbl[3]  = mk("wrAB5",       1,5,16'hAAAA, 1,5,16'h5555, 0,0, 2,2,2, 16'h1234,16'h1234,16'h1234, 0,0,0);
    tbl[4]  = mk("rd5_Bwins",   0,0,16'h0,    0,0,16'h0,    0,0, 5,2,5, 16'h5555,16'h1234,16'h5555, 0,0,0);
    tbl[5]  = mk("pset3",       0,0,16'h0,    0,0,16'h0,    1,3, 0,1,2, 16'h0,16'h0,16'h1234, 0,0,0);
    tbl[6]  = mk("pend3_set",   0,0,16'h0,    0,0,16'h0,    0,0, 0,3,5, 16'h0,16'h0,16'h5555, 0,1,0);
    tbl[7]  = mk("wrB3",        0,0,16'h0,    1,3,16'h0033, 0,0, 0,3,7, 16'h0,(BYP ? 16'h0033 : 16'h0),16'h0, 0,1,0);
    tbl[8]  = mk("pend3_clr",   0,0,16'h0,    0,0,16'h0,    0,0, 0,3,7, 16'h0,16'h0033,16'h0, 0,0,0);
    tbl[9]  = mk("wrA4_pset4",  1,4,16'h4444, 0,0,16'h0,    1,4, 0,1,6, 16'h0,16'h0,16'h0, 0,0,0);
    tbl[10] = mk("pend4_wins",  0,0,16'h0,    0,0,16'h0,    0,0, 4,4,4, 16'h4444,16'h4444,16'h4444, 1,1,1);
    tbl[11] = mk("wrA6_B7",     1,6,16'h6666, 1,7,16'h7777, 0,0, 5,3,2, 16'h5555,16'h0033,16'h1234, 0,0,0);
    tbl[12] = mk("rd674",       0,0,16'h0,    0,0,16'h0,    0,0, 6,7,4, 16'h6666,16'h7777,16'h4444, 0,0,1);

    repeat (3) @(negedge clk);
    nRESET = 1'b1;

    // Table-driven vectors: outputs sampled 1 time unit after the drive, before the edge
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      idle_in();
      wr_en_a = tbl[v].we_a; wr_addr_a = tbl[v].wa; wr_data_a = tbl[v].da;
      wr_en_b = tbl[v].we_b; wr_addr_b = tbl[v].wb; wr_data_b = tbl[v].db;
      pend_set = tbl[v].ps; pend_addr = tbl[v].pa;
      set_rd(tbl[v].ra[0], tbl[v].ra[1], tbl[v].ra[2]);
      for (int p = 0; p < NUM_RD; p++) begin
        push({tbl[v].name, "_data"}, 0, p, tbl[v].ed[p]);
        push({tbl[v].name, "_pend"}, 1, p, {15'd0, tbl[v].ep[p]});
      end
      push({tbl[v].name, "_busy"}, 2, 0, 16'h0);
      #1 check_all();
    end

    // Write-to-read bypass on port 2, addr 1
    @(negedge clk); idle_in(); wr_a(3'd1, 16'h0101); set_rd(3'd0, 3'd0, 3'd1);
    push("byp_pre", 0, 2, BYP ? 16'h0101 : 16'h0000);
    #1 check_all();
    @(negedge clk); idle_in(); wr_a(3'd1, 16'hBEEF); pend_set = 1'b1; pend_addr = 3'd1;
    push("byp_A", 0, 2, BYP ? 16'hBEEF : 16'h0101);
    push("byp_pend_not_fwd", 1, 2, 16'h0);
    #1 check_all();
    @(negedge clk); idle_in(); wr_a(3'd1, 16'h1111);
    wr_en_b = 1'b1; wr_addr_b = 3'd1; wr_data_b = 16'h2222;
    push("byp_B_over_A", 0, 2, BYP ? 16'h2222 : 16'hBEEF);
    push("byp_pend_set", 1, 2, 16'h1);
    #1 check_all();
    @(negedge clk); idle_in();
    push("byp_after", 0, 2, 16'h2222);
    push("byp_pend_cleared", 1, 2, 16'h0);
    #1 check_all();

    // Fill all registers, then run a clear sweep
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle_in(); wr_a(3'(i), 16'hA000 + 16'(i));
    end
    @(negedge clk); idle_in(); clr_req = 1'b1; set_rd(3'd7, 3'd0, 3'd0);
    push("fill_rd7", 0, 0, 16'hA007);
    push("sweep_busy_pre", 2, 0, 16'h0);
    #1 check_all();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); idle_in();
      clr_req = (k < 8);
      if (k == 3) begin
        set_rd(3'd2, 3'd3, 3'd0);
        push("sweep_rd2_cleared", 0, 0, 16'h0);
        push("sweep_rd3_live", 0, 1, 16'hA003);
      end
      if (k == 5) begin
        wr_a(3'd0, 16'hFFFF); pend_set = 1'b1; pend_addr = 3'd0;
      end
      push("sweep_busy", 2, 0, (k < 8) ? 16'h1 : 16'h0);
      #1 check_all();
    end
    for (int a = 0; a < 8; a++) begin
      @(negedge clk); idle_in(); set_rd(3'(a), 3'(a), 3'(7 - a));
      push("post_sweep_data", 0, 0, 16'h0);
      push("post_sweep_data", 0, 2, 16'h0);
      push("post_sweep_pend", 1, 1, 16'h0);
      push("post_sweep_pend", 1, 2, 16'h0);
      #1 check_all();
    end

    // Reset asserted in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle_in(); wr_a(3'(i), 16'h5A00 + 16'(i));
    end
    @(negedge clk); idle_in(); pend_set = 1'b1; pend_addr = 3'd6;
    @(negedge clk); idle_in(); clr_req = 1'b1; set_rd(3'd5, 3'd6, 3'd7);
    push("rst_pre_data5", 0, 0, 16'h5A05);
    push("rst_pre_pend6", 1, 1, 16'h1);
    #1 check_all();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle_in();
      push("rst_sweep_busy", 2, 0, 16'h1);
      #1 check_all();
    end
    @(negedge clk); idle_in(); nRESET = 1'b0;
    push("rst_busy_drop", 2, 0, 16'h0);
    push("rst_data5", 0, 0, 16'h0);
    push("rst_data6", 0, 1, 16'h0);
    push("rst_data7", 0, 2, 16'h0);
    push("rst_pend6", 1, 1, 16'h0);
    #1 check_all();
    @(negedge clk); nRESET = 1'b1; clr_req = 1'b1;
    push("rel_busy_pre", 2, 0, 16'h0);
    #1 check_all();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); idle_in();
      push("rel_sweep_busy", 2, 0, (k < 8) ? 16'h1 : 16'h0);
      #1 check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
